fft_frame_ctrl: RTL
===================

FFT_FRAME_CTRL -- requirements
Module: fft_frame_ctrl

Interface
REQ-001 SHALL have parameter NPTS, default 64, FFT frame length in samples.
REQ-002 SHALL have parameter TIMEOUT, default 4096, maximum clk cycles from input EOP to output SOP.
REQ-003 SHALL have ports:
- clk  in  1  system clock.
- resetNot  in  1  asynchronous active-low reset.
- run  in  1  level; when 1, frames are captured back-to-back.
- sample_tick  in  1  one-cycle pulse; new mic sample present.
- sample  in  12  unsigned offset-binary mic sample.
- sink_valid, sink_sop, sink_eop  out  1 each  FFT Avalon-ST sink controls.
- sink_ready  in  1  FFT sink ready.
- sink_real, sink_imag  out  12 each  signed FFT input.
- sink_error  out  2  FFT sink error.
- fftpts_in  out  7  FFT frame size.
- inverse  out  1  FFT direction.
- source_valid, source_sop, source_eop  in  1 each  FFT output controls.
- source_ready  out  1  FFT output ready.
- source_real, source_imag  in  19 each  signed FFT output.
- peak_bin  out  6  bin with the largest magnitude in the last frame.
- peak_mag  out  20  magnitude of that bin.
- result_valid  out  1  one-cycle pulse when peak_bin and peak_mag update.
- overrun  out  1  sticky; a sample was dropped.
- timeout  out  1  one-cycle pulse; the FFT output did not start in time.

Function
REQ-004 SHALL drive constant outputs: fftpts_in=NPTS, inverse=0, sink_imag=0, sink_error=0.
REQ-005 SHALL convert sample to sink_real by inverting the MSB (sample-2048, two's complement).
REQ-006 SHALL implement FSM states IDLE, FILL, WAIT_OUT, SCAN, REPORT.
REQ-007 IDLE->FILL when run=1; the sample counter clears to 0.
REQ-008 In FILL, on sample_tick with sink_ready=1, SHALL assert sink_valid for exactly that cycle.
- sink_sop=1 when count=0.
- sink_eop=1 when count=NPTS-1.
- count increments on each accepted sample.
REQ-009 In FILL, sample_tick with sink_ready=0 SHALL drop the sample, leave count unchanged, and set overrun.
REQ-010 FILL->WAIT_OUT in the cycle after the EOP beat is accepted.
REQ-011 A run deassertion mid-FILL SHALL NOT abort the frame; it SHALL complete so the FFT stays aligned.
REQ-012 source_ready SHALL be 1 in WAIT_OUT and SCAN, and 0 otherwise.
REQ-013 WAIT_OUT->SCAN on source_valid and source_sop; that beat is bin 0.
REQ-014 A WAIT_OUT cycle counter SHALL time out at TIMEOUT cycles.
- On timeout: pulse timeout and go to IDLE.
- peak outputs unchanged.
REQ-015 For each valid output beat, magnitude SHALL be |re|+|im|.
- Each absolute value saturates to 19 bits (-2^18 maps to 2^18-1).
- Sum is 20 bits unsigned, no overflow.
REQ-016 Only bins 1..NPTS/2-1 SHALL be candidates; DC and mirror bins are ignored.
REQ-017 The candidate with strictly greater magnitude SHALL win; ties keep the lower bin.
REQ-018 If all candidates are 0, the result SHALL be bin 1 with magnitude 0.
REQ-019 SCAN->REPORT on source_eop beat; source_valid gaps SHALL stall the bin counter.
REQ-020 In REPORT (one cycle), SHALL latch peak_bin and peak_mag and pulse result_valid.
- Next state is FILL if run=1, else IDLE.
REQ-021 Latency: result_valid SHALL occur exactly 1 cycle after the source_eop beat.
REQ-022 sample_tick outside FILL SHALL be ignored, with no effect on overrun.

Reset
REQ-023 On resetNot=0, asynchronously:
- state=IDLE; counters=0.
- sink_valid, sink_sop, sink_eop, source_ready=0.
- peak_bin=0, peak_mag=0, result_valid=0, overrun=0, timeout=0.
REQ-024 Reset mid-frame SHALL abandon the frame; the FFT core is reset by the same resetNot.
REQ-025 overrun SHALL clear only on reset.

Structure
REQ-026 Package pitch_pkg SHALL hold:
- the state enum;
- NPTS_DEFAULT, SAMPLE_W=12, FFT_OUT_W=19, MAG_W=20.
REQ-027 Sub-module fft_mag_peak SHALL contain the abs/sum/compare/argmax datapath; fft_frame_ctrl owns the FSM and handshakes.

Verification
REQ-028 Ramp: run=1, 64 ticks, sink_ready=1.
- Exactly 64 sink_valid beats, SOP on beat 0, EOP on beat 63.
- sample 0x000 -> sink_real 0x800; 0xFFF -> 0x7FF.
REQ-029 Overrun: sink_ready=0 on tick 10.
- overrun=1 and stays 1.
- Still 64 accepted beats per frame.
REQ-030 Peak search with model output: bin5 = (1000,-200), bin9 = (600,600), bin 0 = (90000,0).
- Expect peak_bin=5, peak_mag=1200.
- result_valid 1 cycle after EOP.
REQ-031 Tie: bins 3 and 7 both at magnitude 500 -> peak_bin=3.
- Separately, source_real=-262144 -> magnitude contribution 262143.
REQ-032 Timeout: no source_sop for 4096 cycles -> timeout pulse, state IDLE, peak outputs unchanged.
REQ-033 Reset asserted at sample 30 -> all outputs at reset values immediately; next frame restarts with SOP.

Source files
------------

// File: rtl/pitch_pkg.sv
// pitch_pkg: shared types, widths and helpers for the FFT frame controller
package pitch_pkg;
  typedef enum logic [2:0] {IDLE, FILL, WAIT_OUT, SCAN, REPORT} state_t;
  localparam int NPTS_DEFAULT = 64;
  localparam int SAMPLE_W = 12;
  localparam int FFT_OUT_W = 19;
  localparam int MAG_W = 20;
  localparam int CNT_W = 7;
  localparam int BIN_W = 6;
  // The most negative value has no positive twin, so it clamps to the largest positive one.
  function automatic logic [FFT_OUT_W-1:0] abs_sat(input logic signed [FFT_OUT_W-1:0] x);
    return !x[FFT_OUT_W-1] ? x :
           (x == {1'b1, {(FFT_OUT_W-1){1'b0}}}) ? {1'b0, {(FFT_OUT_W-1){1'b1}}} : -x;
  endfunction
endpackage

// File: rtl/fft_frame_ctrl_if.sv
// fft_frame_ctrl_if: Avalon-ST sink/source bundle between the frame controller and the FFT core
//   master: controller side (drives sink_*, fftpts_in, inverse, source_ready)
//   slave:  FFT core side (drives sink_ready, source_valid/sop/eop/real/imag)
interface fft_frame_ctrl_if;
  import pitch_pkg::*;
  logic sink_valid, sink_sop, sink_eop, sink_ready;
  logic [SAMPLE_W-1:0] sink_real, sink_imag;
  logic [1:0] sink_error;
  logic [CNT_W-1:0] fftpts_in;
  logic inverse;
  logic source_valid, source_sop, source_eop, source_ready;
  logic signed [FFT_OUT_W-1:0] source_real, source_imag;
  modport master (
    output sink_valid, sink_sop, sink_eop, sink_real, sink_imag, sink_error, fftpts_in, inverse, source_ready,
    input sink_ready, source_valid, source_sop, source_eop, source_real, source_imag
  );
  modport slave (
    input sink_valid, sink_sop, sink_eop, sink_real, sink_imag, sink_error, fftpts_in, inverse, source_ready,
    output sink_ready, source_valid, source_sop, source_eop, source_real, source_imag
  );
endinterface

// File: rtl/fft_mag_peak.sv
// fft_mag_peak: |re|+|im| magnitude and argmax over the positive-frequency bins of one frame
//   clr: start of frame (bin 0 beat); beat: valid output beat at index bin; done: last beat
//   peak_bin/peak_mag: registered result, updated on done including the last beat
module fft_mag_peak import pitch_pkg::*; #(
  parameter int NPTS = NPTS_DEFAULT
) (
  input  logic                        clk,
  input  logic                        resetNot,
  input  logic                        clr,
  input  logic                        beat,
  input  logic                        done,
  input  logic [CNT_W-1:0]            bin,
  input  logic signed [FFT_OUT_W-1:0] re,
  input  logic signed [FFT_OUT_W-1:0] im,
  output logic [BIN_W-1:0]            peak_bin,
  output logic [MAG_W-1:0]            peak_mag
);
  logic [CNT_W-1:0] best_bin, nxt_bin;
  logic [MAG_W-1:0] best_mag, nxt_mag, mag;
  logic cand;
  // Strict compare keeps the lower bin on ties; DC and mirror bins never qualify.
  always_comb begin
    mag = {1'b0, abs_sat(re)} + {1'b0, abs_sat(im)};
    cand = beat && bin != '0 && bin < CNT_W'(NPTS / 2) && mag > best_mag;
    nxt_bin = cand ? bin : best_bin;
    nxt_mag = cand ? mag : best_mag;
  end
  always_ff @(posedge clk or negedge resetNot)
    if (!resetNot) begin
      best_bin <= CNT_W'(1);
      best_mag <= '0;
      peak_bin <= '0;
      peak_mag <= '0;
    end else begin
      if (clr) begin
        best_bin <= CNT_W'(1);
        best_mag <= '0;
      end else if (beat) begin
        best_bin <= nxt_bin;
        best_mag <= nxt_mag;
      end
      if (done) begin
        peak_bin <= nxt_bin[BIN_W-1:0];
        peak_mag <= nxt_mag;
      end
    end
endmodule

// File: rtl/fft_frame_ctrl.sv
// fft_frame_ctrl: feeds mic samples to an FFT in frames and reports the strongest bin
//   clk, resetNot (async active-low), run, sample_tick, sample: capture control and mic input
//   fft (master): FFT core sink/source handshakes
//   peak_bin, peak_mag, result_valid: per-frame result; overrun (sticky), timeout (pulse): status
module fft_frame_ctrl import pitch_pkg::*; #(
  parameter int NPTS = NPTS_DEFAULT,
  parameter int TIMEOUT = 4096
) (
  input  logic                clk,
  input  logic                resetNot,
  input  logic                run,
  input  logic                sample_tick,
  input  logic [SAMPLE_W-1:0] sample,
  fft_frame_ctrl_if.master    fft,
  output logic [BIN_W-1:0]    peak_bin,
  output logic [MAG_W-1:0]    peak_mag,
  output logic                result_valid,
  output logic                overrun,
  output logic                timeout
);
  localparam int TW = $clog2(TIMEOUT + 1);
  state_t state, nxt;
  logic [CNT_W-1:0] cnt, bin;
  logic [TW-1:0] wcnt;
  logic acc, drop, sop_beat, beat, done, expire;
  assign fft.fftpts_in = CNT_W'(NPTS);
  assign fft.inverse = 1'b0;
  assign fft.sink_imag = '0;
  assign fft.sink_error = '0;
  // Offset-binary to two's complement: flipping the MSB subtracts mid-scale.
  assign fft.sink_real = {~sample[SAMPLE_W-1], sample[SAMPLE_W-2:0]};
  always_comb begin
    acc = state == FILL && sample_tick && fft.sink_ready;
    drop = state == FILL && sample_tick && !fft.sink_ready;
    sop_beat = state == WAIT_OUT && fft.source_valid && fft.source_sop;
    beat = state == SCAN && fft.source_valid;
    done = beat && fft.source_eop;
    expire = state == WAIT_OUT && !sop_beat && wcnt == TW'(TIMEOUT - 1);
    nxt = state;
    case (state)
      IDLE:     nxt = run ? FILL : IDLE;
      FILL:     nxt = acc && cnt == CNT_W'(NPTS - 1) ? WAIT_OUT : FILL;
      WAIT_OUT: nxt = sop_beat ? SCAN : expire ? IDLE : WAIT_OUT;
      SCAN:     nxt = done ? REPORT : SCAN;
      REPORT:   nxt = run ? FILL : IDLE;
      default:  nxt = IDLE;
    endcase
    fft.sink_valid = acc;
    fft.sink_sop = acc && cnt == '0;
    fft.sink_eop = acc && cnt == CNT_W'(NPTS - 1);
    fft.source_ready = state == WAIT_OUT || state == SCAN;
  end
  always_ff @(posedge clk or negedge resetNot)
    if (!resetNot) state <= IDLE;
    else state <= nxt;
  // run is not consulted inside FILL, so a frame always completes and the FFT stays aligned.
  always_ff @(posedge clk or negedge resetNot)
    if (!resetNot) begin
      cnt <= '0;
      bin <= '0;
      wcnt <= '0;
      overrun <= 1'b0;
      timeout <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      cnt <= state != FILL ? '0 : acc ? cnt + 1'b1 : cnt;
      wcnt <= state == WAIT_OUT ? wcnt + 1'b1 : '0;
      bin <= sop_beat ? CNT_W'(1) : beat ? bin + 1'b1 : bin;
      overrun <= overrun | drop;
      timeout <= expire;
      result_valid <= done;
    end
  // The SOP beat is bin 0 and is consumed in WAIT_OUT; it only restarts the search.
  fft_mag_peak #(.NPTS(NPTS)) u_peak (
    .clk      (clk),
    .resetNot (resetNot),
    .clr      (sop_beat),
    .beat     (beat),
    .done     (done),
    .bin      (bin),
    .re       (fft.source_real),
    .im       (fft.source_imag),
    .peak_bin (peak_bin),
    .peak_mag (peak_mag)
  );
endmodule
